// File: rtl/bot_motion_fsm.sv
// Warehouse bot navigation FSM driving the shared 3-bit state bus (PICK_BOX = 101 for the claw).
// Latency: 1 cycle from sampled inputs to registered outputs; no backpressure, inputs are levels.
module bot_motion_fsm #(
    parameter int PICK_CYCLES  = 8,
    parameter int DROP_CYCLES  = 8,
    parameter int OBST_TIMEOUT = 16,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt,
    input  logic             obstacle,
    input  logic             box_detected,
    input  logic             at_drop_zone,
    input  logic             line_left,
    input  logic             line_right,
    input  logic             clear_fault,
    output logic [2:0]       state,
    output logic             carrying,
    output logic [CNT_W-1:0] box_count,
    output logic             fault
);

    localparam int MAXC_A = (PICK_CYCLES > DROP_CYCLES) ? PICK_CYCLES : DROP_CYCLES;
    localparam int MAXC   = (MAXC_A > OBST_TIMEOUT) ? MAXC_A : OBST_TIMEOUT;
    localparam int CW     = $clog2(MAXC + 1);

    localparam logic [CW-1:0] PICK_LAST = CW'(PICK_CYCLES - 1);
    localparam logic [CW-1:0] DROP_LAST = CW'(DROP_CYCLES - 1);
    localparam logic [CW-1:0] OBST_LAST = CW'(OBST_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE          = 3'b000,
        MOVE          = 3'b001,
        TURN_LEFT     = 3'b010,
        TURN_RIGHT    = 3'b011,
        OBSTACLE_WAIT = 3'b100,
        PICK_BOX      = 3'b101,
        DROP_BOX      = 3'b110,
        FAULT         = 3'b111
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carrying_q, carrying_d;
    logic [CNT_W-1:0] box_count_q, box_count_d;
    logic             fault_q;

    // The counter is zero in every state that does not count, so each counting state starts from 0.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        carrying_d  = carrying_q;
        box_count_d = box_count_q;
        case (state_q)
            IDLE: if (start) state_d = MOVE;
            MOVE: begin
                if (halt)                             state_d = IDLE;
                else if (obstacle)                    state_d = OBSTACLE_WAIT;
                else if (!carrying_q && box_detected) state_d = PICK_BOX;
                else if (carrying_q && at_drop_zone)  state_d = DROP_BOX;
                else if (line_left && !line_right)    state_d = TURN_LEFT;
                else if (line_right && !line_left)    state_d = TURN_RIGHT;
            end
            TURN_LEFT: begin
                if (halt)                           state_d = IDLE;
                else if (obstacle)                  state_d = OBSTACLE_WAIT;
                else if (!line_left || line_right)  state_d = MOVE;
            end
            TURN_RIGHT: begin
                if (halt)                           state_d = IDLE;
                else if (obstacle)                  state_d = OBSTACLE_WAIT;
                else if (!line_right || line_left)  state_d = MOVE;
            end
            OBSTACLE_WAIT: begin
                if (!obstacle)               state_d = MOVE;
                else if (cnt_q == OBST_LAST) state_d = FAULT;
                else                         cnt_d   = cnt_q + CW'(1);
            end
            PICK_BOX: begin
                if (cnt_q == PICK_LAST) begin
                    state_d    = MOVE;
                    carrying_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DROP_BOX: begin
                if (cnt_q == DROP_LAST) begin
                    state_d     = MOVE;
                    carrying_d  = 1'b0;
                    box_count_d = box_count_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FAULT:   if (clear_fault) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carrying_q  <= 1'b0;
            box_count_q <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carrying_q  <= carrying_d;
            box_count_q <= box_count_d;
            fault_q     <= (state_d == FAULT);
        end
    end

    assign state     = state_q;
    assign carrying  = carrying_q;
    assign box_count = box_count_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_bot_motion_fsm.sv
// Directed bench for bot_motion_fsm: vector table for steering/priority, hand sequences for dwell, timeout, wrap and reset.
module tb_bot_motion_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, halt, obstacle, box_detected, at_drop_zone;
    logic       line_left, line_right, clear_fault;
    logic [2:0] state;
    logic       carrying;
    logic [7:0] box_count;
    logic       fault;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] exp_count = 8'd0;

    localparam logic [2:0] S_IDLE = 3'b000, S_MOVE = 3'b001, S_TL = 3'b010, S_TR = 3'b011;
    localparam logic [2:0] S_OW = 3'b100, S_PICK = 3'b101, S_DROP = 3'b110, S_FAULT = 3'b111;

    always #5 clk = ~clk;

    bot_motion_fsm #(
        .PICK_CYCLES(8), .DROP_CYCLES(8), .OBST_TIMEOUT(16), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .obstacle(obstacle),
        .box_detected(box_detected), .at_drop_zone(at_drop_zone),
        .line_left(line_left), .line_right(line_right), .clear_fault(clear_fault),
        .state(state), .carrying(carrying), .box_count(box_count), .fault(fault)
    );

    // bit order: start, halt, obstacle, box_detected, at_drop_zone, line_left, line_right, clear_fault
    typedef struct {
        logic [7:0] in;
        logic [2:0] st;
    } vec_t;

    vec_t vecs[26];

    task automatic drive(input logic [7:0] v);
        {start, halt, obstacle, box_detected, at_drop_zone, line_left, line_right, clear_fault} = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] est, input logic ecar, input logic [7:0] ecnt);
        logic efault;
        efault = (est == S_FAULT);
        n_cmp++;
        if (state !== est || carrying !== ecar || box_count !== ecnt || fault !== efault) begin
            n_fail++;
            $display("FAIL %s: got state=%b carrying=%b box_count=%0d fault=%b, want state=%b carrying=%b box_count=%0d fault=%b",
                     name, state, carrying, box_count, fault, est, ecar, ecnt, efault);
        end
    endtask

    // From IDLE: start, pick (8 cycles), drop (8 cycles), back to IDLE via halt.
    task automatic delivery(input string name);
        drive(8'b1000_0000); step(); check({name, "_move"}, S_MOVE, 1'b0, exp_count);
        drive(8'b0001_0000); step(); check({name, "_pick0"}, S_PICK, 1'b0, exp_count);
        drive(8'b0000_0000);
        for (int i = 1; i < 8; i++) begin
            step(); check({name, "_pickdwell"}, S_PICK, 1'b0, exp_count);
        end
        step(); check({name, "_picked"}, S_MOVE, 1'b1, exp_count);
        drive(8'b0000_1000); step(); check({name, "_drop0"}, S_DROP, 1'b1, exp_count);
        drive(8'b0000_0000);
        for (int i = 1; i < 8; i++) begin
            step(); check({name, "_dropdwell"}, S_DROP, 1'b1, exp_count);
        end
        step();
        exp_count = exp_count + 8'd1;
        check({name, "_dropped"}, S_MOVE, 1'b0, exp_count);
        drive(8'b0100_0000); step(); check({name, "_halt"}, S_IDLE, 1'b0, exp_count);
        drive(8'b0000_0000);
    endtask

    initial begin
        vecs[0]  = '{8'b0000_0000, S_IDLE};
        vecs[1]  = '{8'b1000_0000, S_MOVE};
        vecs[2]  = '{8'b0000_0100, S_TL};
        vecs[3]  = '{8'b0000_0110, S_MOVE};
        vecs[4]  = '{8'b0000_0110, S_MOVE};
        vecs[5]  = '{8'b0000_0010, S_TR};
        vecs[6]  = '{8'b0000_0010, S_TR};
        vecs[7]  = '{8'b0000_0000, S_MOVE};
        vecs[8]  = '{8'b0000_0100, S_TL};
        vecs[9]  = '{8'b0000_0010, S_MOVE};
        vecs[10] = '{8'b0000_0010, S_TR};
        vecs[11] = '{8'b0100_0000, S_IDLE};
        vecs[12] = '{8'b1100_0000, S_MOVE};
        vecs[13] = '{8'b0011_0000, S_OW};
        vecs[14] = '{8'b0100_0000, S_MOVE};
        vecs[15] = '{8'b0010_0100, S_OW};
        vecs[16] = '{8'b0110_0000, S_OW};
        vecs[17] = '{8'b0100_0000, S_MOVE};
        vecs[18] = '{8'b0100_0000, S_IDLE};
        vecs[19] = '{8'b1000_0000, S_MOVE};
        vecs[20] = '{8'b0000_0100, S_TL};
        vecs[21] = '{8'b0010_0100, S_OW};
        vecs[22] = '{8'b0000_0000, S_MOVE};
        vecs[23] = '{8'b0000_1000, S_MOVE};
        vecs[24] = '{8'b0100_0000, S_IDLE};
        vecs[25] = '{8'b0000_0001, S_IDLE};

        rst_n = 1'b0;
        drive(8'b0000_0000);
        #12;
        check("reset", S_IDLE, 1'b0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].in);
            step();
            check($sformatf("vec%0d", i), vecs[i].st, 1'b0, 8'd0);
        end
        drive(8'b0000_0000);

        delivery("dlv1");

        // halt and obstacle during PICK do not cut the dwell; halt then acts from MOVE
        drive(8'b1000_0000); step(); check("pri_move", S_MOVE, 1'b0, exp_count);
        drive(8'b0001_0000); step(); check("pri_pick0", S_PICK, 1'b0, exp_count);
        drive(8'b0110_0110);
        for (int i = 1; i < 8; i++) begin
            step(); check("pri_pickdwell", S_PICK, 1'b0, exp_count);
        end
        step(); check("pri_picked", S_MOVE, 1'b1, exp_count);
        step(); check("pri_halt", S_IDLE, 1'b1, exp_count);

        // obstacle for 5 cycles, then release; carrying held
        drive(8'b1000_0000); step(); check("obs_move", S_MOVE, 1'b1, exp_count);
        drive(8'b0010_1000);
        for (int i = 0; i < 5; i++) begin
            step(); check("obs5_wait", S_OW, 1'b1, exp_count);
        end
        drive(8'b0000_0000); step(); check("obs5_release", S_MOVE, 1'b1, exp_count);

        // 16 blocked cycles in OBSTACLE_WAIT -> FAULT
        drive(8'b0010_0000);
        for (int i = 0; i < 16; i++) begin
            step(); check("obs16_wait", S_OW, 1'b1, exp_count);
        end
        step(); check("obs16_fault", S_FAULT, 1'b1, exp_count);
        drive(8'b1111_1110);
        for (int i = 0; i < 3; i++) begin
            step(); check("fault_sticky", S_FAULT, 1'b1, exp_count);
        end
        drive(8'b0000_0001); step(); check("fault_clear", S_IDLE, 1'b1, exp_count);
        drive(8'b0000_0000);

        // drop the held box so later deliveries start empty-handed
        drive(8'b1000_0000); step(); check("rel_move", S_MOVE, 1'b1, exp_count);
        drive(8'b0000_1000); step(); check("rel_drop0", S_DROP, 1'b1, exp_count);
        drive(8'b0000_0000);
        for (int i = 1; i < 8; i++) step();
        step();
        exp_count = exp_count + 8'd1;
        check("rel_done", S_MOVE, 1'b0, exp_count);
        drive(8'b0100_0000); step(); check("rel_halt", S_IDLE, 1'b0, exp_count);
        drive(8'b0000_0000);

        // run deliveries up to 255, then wrap to 0, then one more
        while (exp_count != 8'd255) delivery("bulk");
        check("count_255", S_IDLE, 1'b0, 8'd255);
        delivery("wrap");
        check("count_wrap", S_IDLE, 1'b0, 8'd0);
        delivery("post_wrap");

        // reset mid-DROP aborts immediately
        drive(8'b1000_0000); step();
        drive(8'b0001_0000); step();
        drive(8'b0000_0000);
        for (int i = 0; i < 8; i++) step();
        check("rst_carry", S_MOVE, 1'b1, exp_count);
        drive(8'b0000_1000); step(); check("rst_drop0", S_DROP, 1'b1, exp_count);
        drive(8'b0000_0000);
        step(); step(); step();
        check("rst_dropmid", S_DROP, 1'b1, exp_count);
        #2;
        rst_n = 1'b0;
        #1;
        exp_count = 8'd0;
        check("rst_middrop", S_IDLE, 1'b0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(); check("rst_after", S_IDLE, 1'b0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
